// File: rtl/cdb_arbiter.sv
// Result FIFO per source, round-robin onto one registered CDB; result accepted at edge E is broadcast after E+1.
// src_ready comes only from registered FIFO count; the CDB has no backpressure. CDB_PERF_COUNTERS_EN adds perf counters.
module cdb_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int XLEN       = 32,
    parameter int TAG_W      = $clog2(NUM_SRC),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    RSTN_N,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic                    flush,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
`ifdef CDB_PERF_COUNTERS_EN
    output logic [XLEN-1:0]         cdb_data,
    output logic [31:0]             perf_grants,
    output logic [31:0]             perf_stalls
`else
    output logic [XLEN-1:0]         cdb_data
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
    logic [CNT_W-1:0] cnt_q    [NUM_SRC];
    logic [TAG_W-1:0] rr_ptr_q;
    logic             cdb_valid_q;
    logic [TAG_W-1:0] cdb_tag_q;
    logic [XLEN-1:0]  cdb_data_q;

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_vld;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   idx;
    logic [XLEN-1:0]    head_dat;

    // Slot 0 is the reserved "no producer" tag: never ready, so its FIFO stays empty.
    always_comb begin
        src_ready[0] = 1'b0;
        for (int k = 1; k < NUM_SRC; k++) begin
            src_ready[k] = (cnt_q[k] != CNT_W'(FIFO_DEPTH));
        end
        push = src_valid & src_ready & {NUM_SRC{~flush}};
    end

    // Search starts just after the last winner and ends on it, so a lone busy source keeps winning.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = rr_ptr_q + TAG_W'(i);
            if (!grant_vld && (idx != '0) && (cnt_q[idx] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        head_dat = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        pop = '0;
        if (grant_vld && !flush) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= src_data[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else if (flush) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                if (push[k] && !pop[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end else if (!push[k] && pop[k]) begin
                    cnt_q[k] <= cnt_q[k] - CNT_W'(1);
                end
            end
            cdb_valid_q <= grant_vld;
            cdb_tag_q   <= grant_vld ? grant_idx : '0;
            cdb_data_q  <= grant_vld ? head_dat : '0;
            if (grant_vld) begin
                rr_ptr_q <= grant_idx;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

`ifdef CDB_PERF_COUNTERS_EN
    logic [31:0] perf_grants_q;
    logic [31:0] perf_stalls_q;
    logic        stall;

    assign stall = |(src_valid[NUM_SRC-1:1] & ~src_ready[NUM_SRC-1:1]);

    // Counters only saturate; flush deliberately leaves them alone.
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            perf_grants_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (cdb_valid_q && (perf_grants_q != '1)) perf_grants_q <= perf_grants_q + 32'd1;
            if (stall && (perf_stalls_q != '1))       perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected (tag,data) into a scoreboard,
// a negedge monitor pops per tag whenever the CDB broadcasts.
module tb_cdb_arbiter;
    localparam int NUM_SRC = 8;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 3;

    logic                    CLOCK_50 = 1'b0;
    logic                    RSTN_N;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [NUM_SRC-1:0]      src_ready;
    logic                    flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_data;
`ifdef CDB_PERF_COUNTERS_EN
    logic [31:0]             perf_grants;
    logic [31:0]             perf_stalls;
`endif

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .TAG_W(TAG_W), .FIFO_DEPTH(2)) dut (
        .CLOCK_50  (CLOCK_50),
        .RSTN_N    (RSTN_N),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
`ifdef CDB_PERF_COUNTERS_EN
        .cdb_data  (cdb_data),
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`else
        .cdb_data  (cdb_data)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int bcast_cnt = 0;
    int bench_grants = 0;
    int bench_stalls = 0;
    int seq = 0;
    int found;
    logic [34:0]        exp_q[$];
    logic [34:0]        ent;
    logic [NUM_SRC-1:0] last_acc = '0;
    logic [2:0]         rr_tag [4];
    logic               rr_vld [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor first, then record this cycle's handshakes (they leave the CDB no earlier than two edges later).
    always @(negedge CLOCK_50) begin
        if (cdb_valid === 1'b1) begin
            bcast_cnt++;
            found = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (found < 0 && exp_q[i][34:32] == cdb_tag) found = i;
            end
            if (found < 0) begin
                checks++;
                failures++;
                $display("FAIL cdb_unexpected: got tag %0d data %h, expected no broadcast for that tag", cdb_tag, cdb_data);
            end else begin
                ent = exp_q[found];
                exp_q.delete(found);
                check("cdb_data", cdb_data, ent[31:0]);
            end
        end else begin
            check("idle_tag", {29'b0, cdb_tag}, 32'd0);
            check("idle_data", cdb_data, 32'd0);
        end
        if (!RSTN_N || flush) begin
            exp_q.delete();
            last_acc = '0;
        end else begin
            last_acc = src_valid & src_ready;
            for (int k = 1; k < NUM_SRC; k++) begin
                if (last_acc[k]) exp_q.push_back({3'(k), src_data[k*XLEN +: XLEN]});
            end
        end
        if (!RSTN_N) begin
            bench_grants = 0;
            bench_stalls = 0;
        end else begin
            if (cdb_valid) bench_grants++;
            if (|(src_valid[NUM_SRC-1:1] & ~src_ready[NUM_SRC-1:1])) bench_stalls++;
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        RSTN_N = 1'b0;
        step();
        RSTN_N = 1'b1;
        step();
    endtask

    // Present a fresh value on each masked source whose previous value was taken.
    task automatic traffic_cycle(input logic [NUM_SRC-1:0] mask);
        for (int k = 1; k < NUM_SRC; k++) begin
            if (mask[k] && (!src_valid[k] || last_acc[k])) begin
                seq++;
                src_data[k*XLEN +: XLEN] = {8'(k), 8'hA5, 16'(seq)};
            end
        end
        src_valid = mask;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic filled;
        rr_tag = '{3'd1, 3'd2, 3'd5, 3'd0};
        rr_vld = '{1'b1, 1'b1, 1'b1, 1'b0};
        src_valid = '0;
        src_data  = '0;
        flush     = 1'b0;
        RSTN_N    = 1'b1;
        #1;
        // Reset held with every real source requesting: nothing may be accepted.
        RSTN_N    = 1'b0;
        src_valid = 8'hFE;
        for (int k = 0; k < NUM_SRC; k++) src_data[k*XLEN +: XLEN] = 32'hBAD0_0000 + k;
        repeat (3) step();
        check("rst_valid", {31'b0, cdb_valid}, 32'd0);
        check("rst_tag", {29'b0, cdb_tag}, 32'd0);
        check("rst_data", cdb_data, 32'd0);
        src_valid = '0;
        RSTN_N    = 1'b1;
        step();
        check("rst_ready", {24'b0, src_ready}, 32'h0000_00FE);
        repeat (3) step();

        // Single result from source 3.
        src_data[3*XLEN +: XLEN] = 32'h0000_1234;
        src_valid = 8'h08;
        step();
        src_valid = '0;
        check("single_lat0", {31'b0, cdb_valid}, 32'd0);
        step();
        check("single_valid", {31'b0, cdb_valid}, 32'd1);
        check("single_tag", {29'b0, cdb_tag}, 32'd3);
        check("single_data", cdb_data, 32'h0000_1234);
        step();
        check("single_after", {31'b0, cdb_valid}, 32'd0);

        // Round-robin from rr_ptr=0 over sources 1,2,5.
        do_reset();
        src_data[1*XLEN +: XLEN] = 32'h1111_0001;
        src_data[2*XLEN +: XLEN] = 32'h2222_0002;
        src_data[5*XLEN +: XLEN] = 32'h5555_0005;
        src_valid = 8'h26;
        step();
        src_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_valid", {31'b0, cdb_valid}, {31'b0, rr_vld[i]});
            check("rr_tag", {29'b0, cdb_tag}, {29'b0, rr_tag[i]});
        end

        // Backpressure: sources 1-4 saturating; source 4 takes two then stalls.
        traffic_cycle(8'h1E);
        check("bp_ready4_e0", {31'b0, src_ready[4]}, 32'd1);
        traffic_cycle(8'h1E);
        check("bp_ready4_e1", {31'b0, src_ready[4]}, 32'd0);
        repeat (18) traffic_cycle(8'h1E);
        src_valid = '0;
        repeat (20) step();
        check("bp_drained", exp_q.size(), 32'd0);

        // Flush with FIFOs 1 and 6 full and a same-cycle handshake on source 2.
        filled = 1'b0;
        for (int c = 0; c < 40 && !filled; c++) begin
            traffic_cycle(8'h7A);
            if (!src_ready[1] && !src_ready[6]) filled = 1'b1;
        end
        check("fl_filled", {31'b0, filled}, 32'd1);
        src_data[2*XLEN +: XLEN] = 32'hDEAD_0002;
        src_valid = 8'h46;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        src_valid = '0;
        check("fl_ready", {24'b0, src_ready}, 32'h0000_00FE);
        check("fl_valid", {31'b0, cdb_valid}, 32'd0);
        begin
            int snap;
            snap = bcast_cnt;
            repeat (10) step();
            check("fl_silent", bcast_cnt - snap, 32'd0);
        end

`ifdef CDB_PERF_COUNTERS_EN
        do_reset();
        repeat (20) traffic_cycle(8'h1E);
        check("perf_grants", perf_grants, bench_grants);
        check("perf_stalls", perf_stalls, bench_stalls);
        #2;
        RSTN_N = 1'b0;
        #1;
        check("perf_grants_rst", perf_grants, 32'd0);
        check("perf_stalls_rst", perf_stalls, 32'd0);
        src_valid = '0;
        step();
        RSTN_N = 1'b1;
        step();
`endif

        src_valid = '0;
        repeat (20) step();
        check("final_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
